// File: rtl/lfsr_stream_cipher.sv
// Keystream XOR cipher on a valid/ready stream: Fibonacci LFSR (STEPS shifts per beat)
// feeding a single-entry output register, with runtime rekey, bypass and a beat counter.
module lfsr_stream_cipher #(
  parameter int              WIDTH  = 16,
  parameter int              DATA_W = 8,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter int              STEPS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load,
  input  logic [WIDTH-1:0]  key_in,
  input  logic              bypass,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [15:0]       beat_count
);

  logic [WIDTH-1:0]  state_q, state_d, state_adv;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              accept;

  // STEPS shifts unrolled into one combinational advance per beat
  always_comb begin
    state_adv = state_q;
    for (int i = 0; i < STEPS; i++)
      state_adv = {state_adv[WIDTH-2:0], ^(state_adv & TAPS)};
  end

  assign in_ready = rst_n & ~key_load & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (key_load) begin
      // zero key would lock the LFSR; substitute the seed
      state_d = (key_in == '0) ? SEED : key_in;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = state_adv;
      cnt_d   = cnt_q + 16'd1;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bypass ? in_data : (in_data ^ state_q[DATA_W-1:0]);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEED;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign beat_count = cnt_q;

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Scoreboard bench for lfsr_stream_cipher in the 8-bit configuration (TAPS=E1, SEED=41).
module tb_lfsr_stream_cipher;
  logic clk = 1'b0, rst_n = 1'b0, key_load = 1'b0, bypass = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] key_in = '0, in_data = '0;
  logic in_ready, out_valid;
  logic [7:0] out_data;
  logic [15:0] beat_count;

  lfsr_stream_cipher #(.WIDTH(8), .DATA_W(8), .TAPS(8'hE1), .SEED(8'h41), .STEPS(1)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in), .bypass(bypass),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // reference model
  logic [7:0]  m_st;
  logic        m_ov;
  logic [15:0] m_cnt;
  logic [7:0]  sb[$];
  logic [7:0]  got[$];

  function automatic logic [7:0] step(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hE1)};
  endfunction

  function automatic logic m_rdy();
    return rst_n & ~key_load & (~m_ov | out_ready);
  endfunction

  always @(posedge clk) begin
    logic acc, leave;
    if (!rst_n) begin
      m_st = 8'h41; m_ov = 1'b0; m_cnt = '0; sb.delete();
    end else begin
      acc   = in_valid & m_rdy();
      leave = m_ov & out_ready;
      if (leave && sb.size() > 0) void'(sb.pop_front());
      if (key_load) begin
        m_st  = (key_in == 8'h00) ? 8'h41 : key_in;
        m_cnt = '0;
      end else if (acc) begin
        sb.push_back(bypass ? in_data : (in_data ^ m_st));
        m_st  = step(m_st);
        m_cnt = m_cnt + 16'd1;
      end
      if (acc) m_ov = 1'b1;
      else if (leave) m_ov = 1'b0;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("in_ready", 32'(in_ready), 32'(m_rdy()));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("beat_count", 32'(beat_count), 32'(m_cnt));
    if (out_valid && rst_n) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        chk("out_data", 32'(out_data), 32'(sb[0]));
        if (out_ready) got.push_back(out_data);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; key_load = 1'b0; in_valid = 1'b0; bypass = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
      if (k == 49) chk("send_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_seq(input string tag, input logic [7:0] exp[4], input int n);
    chk({tag, "_len"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < got.size()) chk($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] ct[4];
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(beat_count), 32'd0);
    chk_en = 1'b1;
    out_ready = 1'b1;

    // known-answer stream
    got.delete();
    repeat (4) send(8'h00);
    cyc(2);
    chk_seq("kat", '{8'h41, 8'h82, 8'h05, 8'h0B}, 4);
    chk("kat_count", 32'(beat_count), 32'd4);

    // encrypt then decrypt round trip
    do_reset(); got.delete();
    send(8'hFF); send(8'h12); send(8'h34); send(8'hA5);
    cyc(2);
    chk_seq("enc", '{8'hBE, 8'h90, 8'h31, 8'hAE}, 4);
    for (int i = 0; i < 4; i++) ct[i] = (i < got.size()) ? got[i] : 8'h00;
    do_reset(); got.delete();
    for (int i = 0; i < 4; i++) send(ct[i]);
    cyc(2);
    chk_seq("dec", '{8'hFF, 8'h12, 8'h34, 8'hA5}, 4);

    // backpressure
    do_reset(); got.delete();
    send(8'h01);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h02;
    cyc(5);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_count", 32'(beat_count), 32'd1);
    chk("bp_hold", 32'(out_data), 32'h40);
    out_ready = 1'b1;
    send(8'h02); send(8'h03); send(8'h04);
    cyc(2);
    chk_seq("bp", '{8'h40, 8'h80, 8'h06, 8'h0F}, 4);

    // rekey while input valid
    in_valid = 1'b1; in_data = 8'h00; key_in = 8'h05; key_load = 1'b1;
    @(negedge clk);
    chk("rekey_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    key_load = 1'b0;
    chk("rekey_count", 32'(beat_count), 32'd0);
    got.delete();
    send(8'h00); send(8'h00);
    cyc(2);
    chk_seq("rekey", '{8'h05, 8'h0B, 8'h00, 8'h00}, 2);

    // zero key falls back to seed
    key_in = 8'h00; key_load = 1'b1;
    cyc(1);
    key_load = 1'b0; got.delete();
    send(8'h00);
    cyc(2);
    chk_seq("zkey", '{8'h41, 8'h00, 8'h00, 8'h00}, 1);

    // bypass on beat 2 keeps keystream aligned
    do_reset(); got.delete();
    send(8'h00);
    bypass = 1'b1; send(8'h00);
    bypass = 1'b0; send(8'h00);
    cyc(2);
    chk_seq("byp", '{8'h41, 8'h00, 8'h05, 8'h00}, 3);

    // reset with a held beat
    out_ready = 1'b0;
    send(8'h00);
    chk("held_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    cyc(1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1; got.delete();
    send(8'h00);
    cyc(2);
    chk_seq("midrst", '{8'h41, 8'h00, 8'h00, 8'h00}, 1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
